// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. Computes one bit per cycle
//   (shift-add multiply, restoring divide) on operand magnitudes, then fixes
//   the sign in a single adjust cycle. Divide-by-zero and signed overflow
//   resolve straight from the accept cycle without iterating.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   operation request, taken only in IDLE or DONE
//   flush    in   synchronous abort; wins over start
//   funct3   in   [2:0]  operation select (MUL..REMU)
//   srcA     in   [XLEN] rs1 (multiplicand / dividend)
//   srcB     in   [XLEN] rs2 (multiplier / divisor)
//   busy     out  high in RUN and ADJ
//   done     out  one-cycle result-valid pulse
//   result   out  [XLEN] result, held until the next operation writes it
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ADJ,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [2:0]          r_f3;
   logic                r_neg;
   logic [CNT_W-1:0]    r_cnt;
   logic [XLEN-1:0]     r_op;      // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0]   r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_a_signed;
   logic                w_b_signed;
   logic                w_sign_a;
   logic                w_sign_b;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_neg;
   logic                w_b_zero;
   logic                w_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_special_res;

   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next;
   logic [XLEN:0]       w_rem_sh;
   logic [XLEN:0]       w_diff;
   logic [2*XLEN-1:0]   w_div_next;
   logic [2*XLEN-1:0]   w_acc_step;

   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_mul_res;
   logic [XLEN-1:0]     w_div_sel;
   logic [XLEN-1:0]     w_div_res;
   logic [XLEN-1:0]     w_adj_res;

   // ---------------- accept-time decode ----------------
   always_comb begin
      w_accept   = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
      // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
      // MUL is handled unsigned: the low product half does not depend on signedness.
      w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
      w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      w_sign_a   = w_a_signed && srcA[XLEN-1];
      w_sign_b   = w_b_signed && srcB[XLEN-1];
      w_mag_a    = w_sign_a ? -srcA : srcA;
      w_mag_b    = w_sign_b ? -srcB : srcB;
      // remainder takes the dividend's sign; product and quotient take the xor
      w_neg      = (funct3[2] && funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

      w_b_zero   = (srcB == '0);
      w_ovf      = !funct3[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
      w_special  = funct3[2] && (w_b_zero || w_ovf);
      if (w_b_zero)
         w_special_res = funct3[1] ? srcA : '1;
      else
         w_special_res = funct3[1] ? '0 : srcA;
   end

   // ---------------- one iteration ----------------
   always_comb begin
      // shift-add: add multiplicand into the upper half when multiplier LSB is set,
      // then shift the whole accumulator right (carry enters the MSB)
      w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
      w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

      // restoring divide: shift next dividend bit into the remainder, trial subtract
      w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
      w_diff     = w_rem_sh - {1'b0, r_op};
      if (w_diff[XLEN])
         w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      else
         w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

      w_acc_step = r_f3[2] ? w_div_next : w_mul_next;
   end

   // ---------------- sign fix / select ----------------
   always_comb begin
      w_prod    = r_neg ? -r_acc : r_acc;
      w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      w_div_sel = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
      w_div_res = r_neg ? -w_div_sel : w_div_sel;
      w_adj_res = r_f3[2] ? w_div_res : w_mul_res;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = w_special ? S_DONE : S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == CNT_W'(XLEN - 1))
               w_next = S_ADJ;
         end
         S_ADJ: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (w_accept)
               w_next = w_special ? S_DONE : S_RUN;
            else
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush)
         w_next = S_IDLE;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_f3     <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_f3  <= funct3;
         r_neg <= w_neg;
         r_cnt <= '0;
         if (funct3[2]) begin
            r_op  <= w_mag_b;
            r_acc <= {{XLEN{1'b0}}, w_mag_a};
         end else begin
            r_op  <= w_mag_a;
            r_acc <= {{XLEN{1'b0}}, w_mag_b};
         end
         if (w_special)
            r_result <= w_special_res;
      end else if (!flush) begin
         if (r_state == S_RUN) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (r_state == S_ADJ) begin
            r_result <= w_adj_res;
         end
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        start   = 1'b0;
   logic        flush   = 1'b0;
   logic [2:0]  funct3  = '0;
   logic [31:0] srcA    = '0;
   logic [31:0] srcB    = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_exp = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .flush   (flush),
      .funct3  (funct3),
      .srcA    (srcA),
      .srcB    (srcB),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the architectural definitions.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0]        ua, ub, up;
      logic [31:0]        r;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (f)
         3'd0: begin up = ua * ub;          r = up[31:0];  end
         3'd1: begin sp = sa * sb;          r = sp[63:32]; end
         3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
         3'd3: begin up = ua * ub;          r = up[63:32]; end
         3'd4: begin
            if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin sp = sa / sb; r = sp[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else begin sp = sa % sb; r = sp[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   // Called away from the rising edge; returns right after the accept edge (cycle 0).
   task automatic accept_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      srcA   = a;
      srcB   = b;
      @(posedge clk);
   endtask

   // Samples on falling edges, cycle c after the accept edge. lat=0 means no done seen.
   task automatic run(input int pulse_cyc, input int flush_cyc,
                      output int lat, output int bcnt, output logic [31:0] res);
      lat  = 0;
      bcnt = 0;
      res  = '0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         start = (c == pulse_cyc);
         flush = (c == flush_cyc);
         if (c == pulse_cyc) begin
            funct3 = 3'b101;
            srcA   = 32'd5;
            srcB   = 32'd0;
         end
         if (done) begin
            lat = c;
            res = result;
            break;
         end
         if (busy) bcnt++;
      end
      start = 1'b0;
      flush = 1'b0;
   endtask

   task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      int lat, bcnt;
      logic [31:0] res;
      bit sp;
      sp = is_special(f, a, b);
      accept_op(f, a, b);
      run(-1, -1, lat, bcnt, res);
      chk({tag, " result"}, res, exp);
      chk({tag, " latency"}, lat, sp ? 32'd1 : 32'd34);
      chk({tag, " busy cycles"}, bcnt, sp ? 32'd0 : 32'd33);
      last_exp = exp;
   endtask

   initial begin
      int lat, bcnt, dcnt;
      logic [31:0] res, a, b;
      logic [2:0] f;

      // reset state
      #1 reset_n = 1'b0;
      #2;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // directed arithmetic
      op_check("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      @(negedge clk);
      chk("done one-cycle pulse", done, 0);
      chk("idle after done", busy, 0);
      op_check("MULH min*min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      op_check("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      op_check("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      op_check("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      op_check("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      op_check("DIVU 100/7",    3'b101, 32'd100, 32'd7, 32'd14);
      op_check("REMU 100/7",    3'b111, 32'd100, 32'd7, 32'd2);
      op_check("MUL by zero",   3'b000, 32'h1234_5678, 32'd0, 32'd0);

      // special cases
      op_check("DIVU 5/0",      3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
      op_check("REM 5/0",       3'b110, 32'd5, 32'd0, 32'd5);
      op_check("DIV overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      op_check("REM overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // start during RUN is ignored
      accept_op(3'b000, 32'd7, 32'hFFFF_FFFD);
      run(5, -1, lat, bcnt, res);
      chk("busy-start result", res, 32'hFFFF_FFEB);
      chk("busy-start latency", lat, 34);
      last_exp = 32'hFFFF_FFEB;
      @(negedge clk);
      chk("busy-start no extra done", done, 0);

      // flush mid-operation
      accept_op(3'b101, 32'd100, 32'd7);
      run(-1, 10, lat, bcnt, res);
      chk("flush no done", lat, 0);
      chk("flush busy cycles", bcnt, 10);
      chk("flush result held", result, last_exp);

      // start and flush together in IDLE
      start  = 1'b1;
      flush  = 1'b1;
      funct3 = 3'b101;
      srcA   = 32'd5;
      srcB   = 32'd0;
      @(posedge clk);
      bcnt = 0;
      dcnt = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         if (busy) bcnt++;
         if (done) dcnt++;
      end
      chk("start+flush busy", bcnt, 0);
      chk("start+flush done", dcnt, 0);
      chk("start+flush result", result, last_exp);

      // back-to-back: second accept in the DONE cycle
      op_check("b2b first DIVU", 3'b101, 32'd100, 32'd7, 32'd14);
      op_check("b2b second REMU", 3'b111, 32'd100, 32'd7, 32'd2);

      // randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: a = '0;
            3: b = 32'd1;
            4: b = b >> $urandom_range(1, 31);
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         op_check($sformatf("rand%0d f%0d", i, f), f, a, b, model(f, a, b));
      end

      // asynchronous reset mid-RUN
      @(negedge clk);
      accept_op(3'b000, 32'd7, 32'hFFFF_FFFD);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset busy", busy, 0);
      chk("async reset done", done, 0);
      chk("async reset result", result, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      op_check("post-reset DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
